// File: rtl/drm_sdp_bist.sv
// March-style BIST for a simple dual-port RAM: write a descending pattern, read it back, count mismatches.
// Optional macro DRM_BIST_INV_PASS_EN adds a second pass with inverted data.
module drm_sdp_bist #(
  parameter int ADDR_WIDTH    = 10,
  parameter int DATA_WIDTH    = 8,
  parameter int OUTPUT_REG    = 0,
  parameter int ERR_CNT_WIDTH = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt,
  output logic [ADDR_WIDTH-1:0]    first_err_addr,
  output logic                     mem_wr_en,
  output logic [ADDR_WIDTH-1:0]    mem_wr_addr,
  output logic [DATA_WIDTH-1:0]    mem_wr_data,
  output logic [ADDR_WIDTH-1:0]    mem_rd_addr,
  input  logic [DATA_WIDTH-1:0]    mem_rd_data
);

  localparam int LAT = 1 + OUTPUT_REG;

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;
  logic [1:0]            drain_q, drain_nxt;
  logic                  inv;
  logic                  start_acc;
  logic                  rd_en;
  logic                  mismatch;

  logic                  vld_pipe  [LAT:1];
  logic [ADDR_WIDTH-1:0] addr_pipe [LAT:1];
  logic [DATA_WIDTH-1:0] exp_pipe  [LAT:1];

`ifdef DRM_BIST_INV_PASS_EN
  logic pass_q, pass_nxt;
  assign inv = pass_q;
`else
  assign inv = 1'b0;
`endif

  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] a,
                                                    input logic inv_i);
    logic [DATA_WIDTH-1:0] a_ext;
    a_ext = DATA_WIDTH'(a);
    return ({DATA_WIDTH{1'b1}} - a_ext) ^ {DATA_WIDTH{inv_i}};
  endfunction

  assign start_acc = start && (state == IDLE || state == DONE);
  assign rd_en     = (state == READ);

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr_q;
    drain_nxt = drain_q;
`ifdef DRM_BIST_INV_PASS_EN
    pass_nxt  = pass_q;
`endif
    case (state)
      IDLE, DONE: if (start) begin
        state_nxt = WRITE;
        addr_nxt  = '0;
`ifdef DRM_BIST_INV_PASS_EN
        pass_nxt  = 1'b0;
`endif
      end
      WRITE: begin
        addr_nxt = addr_q + 1'b1;
        if (addr_q == '1) state_nxt = READ;
      end
      READ: begin
        addr_nxt = addr_q + 1'b1;
        if (addr_q == '1) begin
          state_nxt = DRAIN;
          drain_nxt = '0;
        end
      end
      DRAIN: begin
        drain_nxt = drain_q + 1'b1;
        if (drain_q == 2'(LAT - 1)) begin
`ifdef DRM_BIST_INV_PASS_EN
          if (!pass_q) begin
            state_nxt = WRITE;
            pass_nxt  = 1'b1;
          end else
            state_nxt = DONE;
`else
          state_nxt = DONE;
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      addr_q  <= '0;
      drain_q <= '0;
`ifdef DRM_BIST_INV_PASS_EN
      pass_q  <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      addr_q  <= addr_nxt;
      drain_q <= drain_nxt;
`ifdef DRM_BIST_INV_PASS_EN
      pass_q  <= pass_nxt;
`endif
    end
  end

  // Expected data/address travel alongside the RAM read latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i <= LAT; i++) begin
        vld_pipe[i]  <= 1'b0;
        addr_pipe[i] <= '0;
        exp_pipe[i]  <= '0;
      end
    end else begin
      vld_pipe[1]  <= rd_en;
      addr_pipe[1] <= addr_q;
      exp_pipe[1]  <= pattern(addr_q, inv);
      for (int i = 2; i <= LAT; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        addr_pipe[i] <= addr_pipe[i-1];
        exp_pipe[i]  <= exp_pipe[i-1];
      end
    end
  end

  assign mismatch = vld_pipe[LAT] && (mem_rd_data != exp_pipe[LAT]);

  // err_cnt==0 doubles as "no mismatch yet" since it saturates instead of wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt        <= '0;
      first_err_addr <= '0;
    end else if (start_acc) begin
      err_cnt        <= '0;
      first_err_addr <= '0;
    end else if (mismatch) begin
      if (err_cnt == '0) first_err_addr <= addr_pipe[LAT];
      if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
    end
  end

  assign busy        = (state == WRITE) || (state == READ) || (state == DRAIN);
  assign done        = (state == DONE);
  assign pass        = done && (err_cnt == '0);
  assign mem_wr_en   = (state == WRITE);
  assign mem_wr_addr = mem_wr_en ? addr_q : '0;
  assign mem_wr_data = mem_wr_en ? pattern(addr_q, inv) : '0;
  assign mem_rd_addr = rd_en ? addr_q : '0;

endmodule

// File: tb/tb_drm_sdp_bist.sv
// Scoreboard bench for drm_sdp_bist: two instances (OUTPUT_REG 0 and 1) driving behavioural RAM models.
module tb_drm_sdp_bist;

`ifdef DRM_BIST_INV_PASS_EN
  localparam int NP = 2;
  localparam logic [7:0] MEM5 = 8'h05;
  localparam logic [7:0] MEM0 = 8'h00;
`else
  localparam int NP = 1;
  localparam logic [7:0] MEM5 = 8'hFA;
  localparam logic [7:0] MEM0 = 8'hFF;
`endif

  typedef struct {
    string name;
    int    busy_len;
    int    err;
    int    fea;     // -1: don't check
    bit    pass;
  } exp_t;

  logic clk = 0;
  logic rst_n = 0;
  logic start0 = 0, start1 = 0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // DUT0: OUTPUT_REG=0
  logic       busy0, done0, pass0, wren0;
  logic [2:0] err0;
  logic [3:0] fea0, wra0, rda0;
  logic [7:0] wrd0, rdd0;
  // DUT1: OUTPUT_REG=1
  logic       busy1, done1, pass1, wren1;
  logic [2:0] err1;
  logic [3:0] fea1, wra1, rda1;
  logic [7:0] wrd1, rdd1;

  drm_sdp_bist #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .OUTPUT_REG(0), .ERR_CNT_WIDTH(3)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .busy(busy0), .done(done0), .pass(pass0),
    .err_cnt(err0), .first_err_addr(fea0), .mem_wr_en(wren0), .mem_wr_addr(wra0),
    .mem_wr_data(wrd0), .mem_rd_addr(rda0), .mem_rd_data(rdd0));

  drm_sdp_bist #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .OUTPUT_REG(1), .ERR_CNT_WIDTH(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1), .pass(pass1),
    .err_cnt(err1), .first_err_addr(fea1), .mem_wr_en(wren1), .mem_wr_addr(wra1),
    .mem_wr_data(wrd1), .mem_rd_addr(rda1), .mem_rd_data(rdd1));

  // RAM models; mode0: 0 ideal, 1 flip bit0 @5, 2 bit7 stuck 0, 3 two-cycle latency
  int         mode0 = 0;
  int         wr_cnt0 = 0;
  logic [7:0] mem0 [16];
  logic [7:0] m0_q1 = 0, m0_q2 = 0;
  logic [7:0] mem1 [16];
  logic [7:0] m1_q1 = 0, m1_q2 = 0;

  function automatic logic [7:0] fault(input logic [7:0] d, input logic [3:0] a, input int m);
    if (m == 1 && a == 4'd5) return d ^ 8'h01;
    if (m == 2) return d & 8'h7F;
    return d;
  endfunction

  initial for (int i = 0; i < 16; i++) begin mem0[i] = 0; mem1[i] = 0; end

  always @(posedge clk) begin
    if (wren0) begin mem0[wra0] <= wrd0; wr_cnt0 <= wr_cnt0 + 1; end
    m0_q1 <= fault(mem0[rda0], rda0, mode0);
    m0_q2 <= m0_q1;
    if (wren1) mem1[wra1] <= wrd1;
    m1_q1 <= mem1[rda1];
    m1_q2 <= m1_q1;
  end
  assign rdd0 = (mode0 == 3) ? m0_q2 : m0_q1;
  assign rdd1 = m1_q2;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  exp_t q0[$], q1[$];

  // Monitors: on each rising done, compare the outcome against the queued expectation
  int bc0 = 0, bc1 = 0;
  logic dp0 = 0, dp1 = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      bc0 = 0; dp0 = 0;
    end else begin
      if (busy0) bc0++;
      if (done0 && !dp0) begin
        if (q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL dut0_unexpected_done: got done=1 expected no completion");
        end else begin
          e = q0.pop_front();
          check({e.name, "_busy_len"}, 64'(bc0), 64'(e.busy_len));
          check({e.name, "_pass"}, 64'(pass0), 64'(e.pass));
          check({e.name, "_err_cnt"}, 64'(err0), 64'(e.err));
          if (e.fea >= 0) check({e.name, "_first_err"}, 64'(fea0), 64'(e.fea));
        end
        bc0 = 0;
      end
      dp0 = done0;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      bc1 = 0; dp1 = 0;
    end else begin
      if (busy1) bc1++;
      if (done1 && !dp1) begin
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL dut1_unexpected_done: got done=1 expected no completion");
        end else begin
          e = q1.pop_front();
          check({e.name, "_busy_len"}, 64'(bc1), 64'(e.busy_len));
          check({e.name, "_pass"}, 64'(pass1), 64'(e.pass));
          check({e.name, "_err_cnt"}, 64'(err1), 64'(e.err));
          if (e.fea >= 0) check({e.name, "_first_err"}, 64'(fea1), 64'(e.fea));
        end
        bc1 = 0;
      end
      dp1 = done1;
    end
  end

  task automatic pulse(input int which);
    @(posedge clk); #1;
    if (which == 0) start0 = 1; else start1 = 1;
    @(posedge clk); #1;
    start0 = 0; start1 = 0;
  endtask

  task automatic wait_done(input int which, input string name);
    bit seen = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if ((which == 0 && done0) || (which == 1 && done1)) begin seen = 1; break; end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got no done expected done within 400 cycles", name);
    end
    @(negedge clk);
  endtask

  task automatic run0(input exp_t e);
    q0.push_back(e);
    pulse(0);
    wait_done(0, e.name);
  endtask

  initial begin
    int wc;
    rst_n = 0;
    #12;
    check("reset_outputs_dut0", {busy0, done0, pass0, err0, fea0, wren0, wra0, wrd0, rda0}, 64'd0);
    check("reset_outputs_dut1", {busy1, done1, pass1, err1, fea1, wren1, wra1, wrd1, rda1}, 64'd0);
    @(posedge clk); #1 rst_n = 1;
    repeat (2) @(posedge clk);

    mode0 = 0; run0('{"ideal", NP*33, 0, 0, 1'b1});
    check("ideal_done", 64'(done0), 64'd1);
    check("ideal_mem5", 64'(mem0[5]), 64'(MEM5));
    check("ideal_mem0", 64'(mem0[0]), 64'(MEM0));
    check("ideal_wr_count", 64'(wr_cnt0), 64'(NP*16));

    mode0 = 1; run0('{"flip5", NP*33, NP, 5, 1'b0});
    mode0 = 2; run0('{"stuck7", NP*33, 7, 0, 1'b0});
    mode0 = 3; run0('{"lat2_oreg0", NP*33, 7, -1, 1'b0});

    q1.push_back('{"lat2_oreg1", NP*34, 0, 0, 1'b1});
    pulse(1);
    wait_done(1, "lat2_oreg1");

    // start re-pulsed mid-test must not restart or extend
    mode0 = 0;
    q0.push_back('{"repulse", NP*33, 0, 0, 1'b1});
    pulse(0);
    repeat (8) @(posedge clk);
    pulse(0);
    repeat (20) @(posedge clk);
    pulse(0);
    wait_done(0, "repulse");

    // reset during READ aborts: outputs drop at once, no writes, no done
    pulse(0);
    repeat (19) @(posedge clk);
    #1;
    check("in_read_before_reset", 64'(rda0 != 0), 64'd1);
    wc = wr_cnt0;
    rst_n = 0;
    #1;
    check("midreset_outputs", {busy0, done0, pass0, err0, fea0, wren0, wra0, wrd0, rda0}, 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    repeat (10) @(posedge clk);
    #1;
    check("midreset_no_writes", 64'(wr_cnt0), 64'(wc));
    check("midreset_no_done", 64'(done0), 64'd0);

    run0('{"after_reset", NP*33, 0, 0, 1'b1});

    repeat (3) @(posedge clk);
    check("scoreboard_empty", 64'(q0.size() + q1.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
